// File: rtl/video_scroll_unit.sv
// PPU scroll/address unit: loopy v/t registers, fine X, shared write latch and a
// req/ack PPUDATA port toward the video bus arbiter with CPU-side nametable mirroring.
module video_scroll_unit #(
  parameter int P_fine_width    = 3,
  parameter int P_rows          = 30,
  parameter bit P_mirror_enable = 1'b1
) (
  input  logic                      I_clock,
  input  logic                      I_reset,
  input  logic [7:0]                I_wren,
  input  logic [7:0]                I_rden,
  input  logic [7:0]                I_data,
  output logic [7:0]                O_data,
  input  logic [7:0]                I_ppuctrl,
  input  logic [1:0]                I_mirror,
  input  logic                      I_render,
  input  logic                      I_incr_hori,
  input  logic                      I_incr_vert,
  input  logic                      I_hori_copy,
  input  logic                      I_vert_copy,
  output logic                      O_vid_req,
  input  logic                      I_vid_ack,
  output logic [13:0]               O_vid_addr,
  output logic                      O_vid_wren,
  output logic [7:0]                O_vid_data,
  input  logic [7:0]                I_vid_data,
  output logic [12+P_fine_width-1:0] O_v_addr,
  output logic [P_fine_width-1:0]   O_fine_x,
  output logic                      O_overrun
);

  localparam int VW       = 12 + P_fine_width;
  localparam int REG_CTRL = 0;
  localparam int REG_STAT = 2;
  localparam int REG_SCRL = 5;
  localparam int REG_ADDR = 6;
  localparam int REG_DATA = 7;

  localparam logic [4:0]              ROW_LAST = 5'(P_rows - 1);
  localparam logic [P_fine_width-1:0] FINE_ONE = P_fine_width'(1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           v_q, v_d, t_q, t_d, v_inc, v_adv;
  logic [P_fine_width-1:0] fine_x_d;
  logic                    w_q, w_d;

  // Register decode; ctrl beats addr beats scrl if several strobes collide.
  logic wr_ctrl, wr_addr, wr_scrl, rd_stat, data_stb, accept, ack_done;

  assign wr_ctrl  = I_wren[REG_CTRL];
  assign wr_addr  = I_wren[REG_ADDR] & ~wr_ctrl;
  assign wr_scrl  = I_wren[REG_SCRL] & ~wr_ctrl & ~I_wren[REG_ADDR];
  assign rd_stat  = I_rden[REG_STAT];
  assign data_stb = I_wren[REG_DATA] | I_rden[REG_DATA];
  assign accept   = (state_q == S_IDLE) & data_stb;
  assign ack_done = (state_q == S_REQ) & I_vid_ack;

  logic unused_inputs;
  assign unused_inputs = ^{I_wren[4:1], I_rden[6:3], I_rden[1:0],
                           I_ppuctrl[7:3], I_ppuctrl[1:0]};

  function automatic logic [VW-1:0] incr_x(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    if (v[4:0] == 5'd31) begin
      r[4:0] = 5'd0;
      r[10]  = ~v[10];
    end else begin
      r[4:0] = v[4:0] + 5'd1;
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] incr_y(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    if (v[VW-1:12] != '1) begin
      r[VW-1:12] = v[VW-1:12] + FINE_ONE;
    end else begin
      r[VW-1:12] = '0;
      if (v[9:5] == ROW_LAST) begin
        r[9:5] = 5'd0;
        r[11]  = ~v[11];
      end else if (v[9:5] == 5'd31) begin
        r[9:5] = 5'd0;
      end else begin
        r[9:5] = v[9:5] + 5'd1;
      end
    end
    return r;
  endfunction

  // Nametable folding for CPU accesses in the 0x2000-0x2FFF window.
  function automatic logic [13:0] mirror(input logic [13:0] a, input logic [1:0] mode);
    logic [13:0] r;
    r = a;
    if (P_mirror_enable && (a[13:12] == 2'b10)) begin
      case (mode)
        2'd0:    r[11] = 1'b0;
        2'd1:    begin r[10] = a[11]; r[11] = 1'b0; end
        2'd2:    r[11:10] = 2'b00;
        default: r[11:10] = 2'b01;
      endcase
    end
    return r;
  endfunction

  // During rendering the PPUDATA advance becomes a coarse-X plus Y increment.
  assign v_inc = I_ppuctrl[2] ? VW'(32) : VW'(1);
  assign v_adv = I_render ? incr_y(incr_x(v_q)) : (v_q + v_inc);

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (data_stb)  state_d = S_REQ;
      S_REQ:   if (I_vid_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    t_d      = t_q;
    fine_x_d = O_fine_x;
    if (wr_ctrl) begin
      t_d[11:10] = I_data[1:0];
    end else if (wr_addr) begin
      if (!w_q) begin
        t_d[13:8]    = I_data[5:0];
        t_d[VW-1:14] = '0;
      end else begin
        t_d[7:0] = I_data;
      end
    end else if (wr_scrl) begin
      if (!w_q) begin
        t_d[4:0] = I_data[7:3];
        fine_x_d = P_fine_width'(I_data[2:0]);
      end else begin
        t_d[9:5]     = I_data[7:3];
        t_d[VW-1:12] = P_fine_width'(I_data[2:0]);
      end
    end
  end

  always_comb begin
    v_d = v_q;
    if (wr_addr && w_q) begin
      v_d = {t_q[VW-1:8], I_data};
    end else if (ack_done) begin
      v_d = v_adv;
    end else if (I_render) begin
      if (I_incr_hori) begin
        v_d = incr_x(v_q);
      end else if (I_incr_vert) begin
        v_d = incr_y(v_q);
      end else if (I_hori_copy) begin
        v_d[10]  = t_q[10];
        v_d[4:0] = t_q[4:0];
      end else if (I_vert_copy) begin
        v_d[11]      = t_q[11];
        v_d[9:5]     = t_q[9:5];
        v_d[VW-1:12] = t_q[VW-1:12];
      end
    end
  end

  always_comb begin
    w_d = w_q;
    if (rd_stat)                w_d = 1'b0;
    else if (wr_addr | wr_scrl) w_d = ~w_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q    <= S_IDLE;
      v_q        <= '0;
      t_q        <= '0;
      O_fine_x   <= '0;
      w_q        <= 1'b0;
      O_overrun  <= 1'b0;
      O_data     <= 8'h00;
      O_vid_wren <= 1'b0;
      O_vid_data <= 8'h00;
      O_vid_addr <= 14'h0000;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      t_q      <= t_d;
      O_fine_x <= fine_x_d;
      w_q      <= w_d;
      if (rd_stat)
        O_overrun <= 1'b0;
      else if ((state_q == S_REQ) && data_stb)
        O_overrun <= 1'b1;
      if (accept) begin
        O_vid_wren <= I_wren[REG_DATA];
        O_vid_data <= I_data;
        O_vid_addr <= mirror(v_q[13:0], I_mirror);
      end
      if (ack_done && !O_vid_wren)
        O_data <= I_vid_data;
    end
  end

  assign O_vid_req = (state_q == S_REQ);
  assign O_v_addr  = v_q;

endmodule

// File: tb/tb_video_scroll_unit.sv
// Directed bench for video_scroll_unit: register writes, PPUDATA handshake,
// mirroring, overrun, render updates and the rendering increment glitch.
module tb_video_scroll_unit;

  localparam int REG_CTRL = 0;
  localparam int REG_STAT = 2;
  localparam int REG_SCRL = 5;
  localparam int REG_ADDR = 6;
  localparam int REG_DATA = 7;

  logic        I_clock, I_reset;
  logic [7:0]  I_wren, I_rden, I_data, O_data, I_ppuctrl;
  logic [1:0]  I_mirror;
  logic        I_render, I_incr_hori, I_incr_vert, I_hori_copy, I_vert_copy;
  logic        O_vid_req, I_vid_ack, O_vid_wren, O_overrun;
  logic [13:0] O_vid_addr;
  logic [7:0]  O_vid_data, I_vid_data;
  logic [14:0] O_v_addr;
  logic [2:0]  O_fine_x;

  int n_checks = 0;
  int n_fail   = 0;

  video_scroll_unit dut (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
    .I_wren     (I_wren),
    .I_rden     (I_rden),
    .I_data     (I_data),
    .O_data     (O_data),
    .I_ppuctrl  (I_ppuctrl),
    .I_mirror   (I_mirror),
    .I_render   (I_render),
    .I_incr_hori(I_incr_hori),
    .I_incr_vert(I_incr_vert),
    .I_hori_copy(I_hori_copy),
    .I_vert_copy(I_vert_copy),
    .O_vid_req  (O_vid_req),
    .I_vid_ack  (I_vid_ack),
    .O_vid_addr (O_vid_addr),
    .O_vid_wren (O_vid_wren),
    .O_vid_data (O_vid_data),
    .I_vid_data (I_vid_data),
    .O_v_addr   (O_v_addr),
    .O_fine_x   (O_fine_x),
    .O_overrun  (O_overrun)
  );

  initial I_clock = 1'b0;
  always #5 I_clock = ~I_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge I_clock);
    #1;
  endtask

  task automatic wr_reg(input int idx, input logic [7:0] d);
    I_data      = d;
    I_wren[idx] = 1'b1;
    tick();
    I_wren = '0;
  endtask

  task automatic rd_stat();
    I_rden[REG_STAT] = 1'b1;
    tick();
    I_rden = '0;
  endtask

  task automatic start_data(input logic is_wr, input logic [7:0] d);
    I_data = d;
    if (is_wr) I_wren[REG_DATA] = 1'b1;
    else       I_rden[REG_DATA] = 1'b1;
    tick();
    I_wren = '0;
    I_rden = '0;
  endtask

  task automatic ack(input logic [7:0] d);
    I_vid_ack  = 1'b1;
    I_vid_data = d;
    tick();
    I_vid_ack  = 1'b0;
    I_vid_data = 8'h00;
  endtask

  task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
    wr_reg(REG_ADDR, hi);
    wr_reg(REG_ADDR, lo);
  endtask

  initial begin
    I_reset = 1'b0; I_wren = '0; I_rden = '0; I_data = '0; I_ppuctrl = '0;
    I_mirror = 2'd0; I_render = 1'b0; I_incr_hori = 1'b0; I_incr_vert = 1'b0;
    I_hori_copy = 1'b0; I_vert_copy = 1'b0; I_vid_ack = 1'b0; I_vid_data = '0;
    tick();
    tick();
    check("rst_v", O_v_addr, 15'h0000);
    check("rst_fine_x", O_fine_x, 3'd0);
    check("rst_data", O_data, 8'h00);
    check("rst_overrun", O_overrun, 1'b0);
    check("rst_req", O_vid_req, 1'b0);
    check("rst_wren", O_vid_wren, 1'b0);
    I_reset = 1'b1;
    tick();

    // Address load and a data write with a delayed grant.
    set_v(8'h21, 8'h08);
    check("addr_load_v", O_v_addr, 15'h2108);
    start_data(1'b1, 8'h55);
    check("wr_req", O_vid_req, 1'b1);
    check("wr_addr_mirror0", O_vid_addr, 14'h2108);
    check("wr_wren", O_vid_wren, 1'b1);
    check("wr_data", O_vid_data, 8'h55);
    tick();
    tick();
    check("wr_req_held", O_vid_req, 1'b1);
    check("wr_v_not_yet", O_v_addr, 15'h2108);
    ack(8'h00);
    check("wr_req_drop", O_vid_req, 1'b0);
    check("wr_v_adv", O_v_addr, 15'h2109);

    // Back-to-back read right after the grant.
    start_data(1'b0, 8'h00);
    check("b2b_req", O_vid_req, 1'b1);
    check("b2b_wren", O_vid_wren, 1'b0);
    check("b2b_addr", O_vid_addr, 14'h2109);
    ack(8'h11);
    check("b2b_data", O_data, 8'h11);
    check("b2b_v", O_v_addr, 15'h210A);

    // Increment by 32 across the 14-bit boundary.
    I_ppuctrl = 8'h04;
    set_v(8'h3F, 8'hF0);
    start_data(1'b0, 8'h00);
    check("inc32_addr0", O_vid_addr, 14'h3FF0);
    ack(8'hAA);
    check("inc32_data0", O_data, 8'hAA);
    check("inc32_v0", O_v_addr, 15'h4010);
    start_data(1'b0, 8'h00);
    check("inc32_addr1", O_vid_addr, 14'h0010);
    ack(8'hBB);
    check("inc32_data1", O_data, 8'hBB);
    check("inc32_v1", O_v_addr, 15'h4030);
    I_ppuctrl = 8'h00;

    // Mirroring modes on v = 0x2C05.
    I_mirror = 2'd1;
    set_v(8'h2C, 8'h05);
    start_data(1'b0, 8'h00);
    check("mirror_h", O_vid_addr, 14'h2405);
    ack(8'h01);
    I_mirror = 2'd3;
    set_v(8'h2C, 8'h05);
    start_data(1'b0, 8'h00);
    check("mirror_hi", O_vid_addr, 14'h2405);
    ack(8'h02);
    I_mirror = 2'd2;
    set_v(8'h2C, 8'h05);
    start_data(1'b0, 8'h00);
    check("mirror_lo", O_vid_addr, 14'h2005);
    ack(8'h03);
    I_mirror = 2'd0;
    set_v(8'h2C, 8'h05);
    start_data(1'b0, 8'h00);
    check("mirror_v", O_vid_addr, 14'h2405);
    ack(8'h04);
    check("mirror_v_after", O_v_addr, 15'h2C06);

    // Overrun: second data strobe while busy is dropped; stat read clears flag and w.
    start_data(1'b1, 8'h77);
    start_data(1'b1, 8'h99);
    check("ovr_flag", O_overrun, 1'b1);
    check("ovr_req", O_vid_req, 1'b1);
    check("ovr_data_kept", O_vid_data, 8'h77);
    check("ovr_addr_kept", O_vid_addr, 14'h2406);
    wr_reg(REG_ADDR, 8'h12);
    ack(8'h00);
    check("ovr_v", O_v_addr, 15'h2C07);
    check("ovr_sticky", O_overrun, 1'b1);
    rd_stat();
    check("stat_clr_ovr", O_overrun, 1'b0);
    set_v(8'h23, 8'h45);
    check("stat_clr_w", O_v_addr, 15'h2345);

    // Scroll writes and copies into v.
    wr_reg(REG_SCRL, 8'h7D);
    check("scrl_fine_x", O_fine_x, 3'd5);
    wr_reg(REG_SCRL, 8'h5E);
    I_render = 1'b1;
    I_vert_copy = 1'b1; tick(); I_vert_copy = 1'b0;
    check("vcopy", O_v_addr, 15'h6165);
    I_hori_copy = 1'b1; tick(); I_hori_copy = 1'b0;
    check("hcopy", O_v_addr, 15'h616F);

    // Y increment at the last row and at row 31.
    wr_reg(REG_SCRL, 8'h00);
    check("scrl_fine_x0", O_fine_x, 3'd0);
    wr_reg(REG_SCRL, 8'hEF);
    I_vert_copy = 1'b1; tick(); I_vert_copy = 1'b0;
    check("vcopy_row29", O_v_addr, 15'h73AF);
    I_incr_vert = 1'b1; tick(); I_incr_vert = 1'b0;
    check("incy_row29", O_v_addr, 15'h080F);
    wr_reg(REG_SCRL, 8'h00);
    wr_reg(REG_SCRL, 8'hFF);
    I_vert_copy = 1'b1; tick(); I_vert_copy = 1'b0;
    check("vcopy_row31", O_v_addr, 15'h73EF);
    I_incr_vert = 1'b1; tick(); I_incr_vert = 1'b0;
    check("incy_row31", O_v_addr, 15'h000F);
    I_incr_hori = 1'b1; tick(); I_incr_hori = 1'b0;
    check("incx", O_v_addr, 15'h0010);

    // Rendering glitch on a PPUDATA read; a same-cycle render pulse loses.
    wr_reg(REG_CTRL, 8'h00);
    wr_reg(REG_SCRL, 8'hF8);
    wr_reg(REG_SCRL, 8'h07);
    I_hori_copy = 1'b1; tick(); I_hori_copy = 1'b0;
    I_vert_copy = 1'b1; tick(); I_vert_copy = 1'b0;
    check("glitch_v_pre", O_v_addr, 15'h701F);
    start_data(1'b0, 8'h00);
    check("glitch_addr", O_vid_addr, 14'h301F);
    I_incr_hori = 1'b1;
    ack(8'hC3);
    I_incr_hori = 1'b0;
    check("glitch_v", O_v_addr, 15'h0420);
    check("glitch_data", O_data, 8'hC3);

    // Second addr write beats a simultaneous render update.
    wr_reg(REG_ADDR, 8'h01);
    I_incr_hori = 1'b1;
    wr_reg(REG_ADDR, 8'h02);
    I_incr_hori = 1'b0;
    check("addr_over_render", O_v_addr, 15'h0102);
    I_render = 1'b0;

    // Reset in the middle of a pending access.
    start_data(1'b0, 8'h00);
    check("rstmid_req_before", O_vid_req, 1'b1);
    #2;
    I_reset   = 1'b0;
    I_vid_ack = 1'b1;
    #1;
    check("rstmid_req_async", O_vid_req, 1'b0);
    check("rstmid_v", O_v_addr, 15'h0000);
    check("rstmid_data", O_data, 8'h00);
    tick();
    check("rstmid_req_held", O_vid_req, 1'b0);
    I_vid_ack = 1'b0;
    I_reset   = 1'b1;
    tick();
    check("rstmid_req_after", O_vid_req, 1'b0);
    check("rstmid_v_after", O_v_addr, 15'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
